branch_control_unit: RTL and testbench

// - Sequences the BRANCH_CALCULATOR for the pipelined RAT core.
// - Detects a branch in ID and stalls the front end while a flag-writing instruction is in flight.
// - Drives the calculator with the latched type and resolved C/Z, then on a taken branch issues
//   the PC load and the IF/ID flushes. Keeps saturating branch/taken statistics counters.

---
 rtl/branch_control_unit_pkg.sv | 24 ++
 rtl/branch_control_unit_stat_counter.sv | 20 ++
 rtl/branch_control_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_control_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_control_unit_pkg.sv
// Shared branch-type codes and FSM state encoding for the branch control unit.
package branch_control_unit_pkg;

    // Branch type codes as decoded in ID and consumed by the branch calculator.
    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BRN  = 4'd1;
    localparam logic [3:0] BR_BREQ = 4'd2;
    localparam logic [3:0] BR_BRNE = 4'd3;
    localparam logic [3:0] BR_BRCS = 4'd4;
    localparam logic [3:0] BR_BRCC = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESOLVE  = 2'd2,
        ST_REDIRECT = 2'd3
    } bcu_state_t;

    // Any code other than BR_NONE is a branch; reserved codes are passed through.
    function automatic logic is_branch(input logic [3:0] br_type);
        return br_type != BR_NONE;
    endfunction

endpackage

// File: rtl/branch_control_unit_stat_counter.sv
// Saturating event counter used for branch statistics.
module branch_stat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_control_unit.sv
// Branch control unit: detects a branch in ID, stalls the front end until the
// flags are valid, drives the branch calculator for one cycle and, on a taken
// branch, loads the PC and squashes the fetched instruction.
//
// Pipeline control semantics: STALL holds PC and IF/ID for every cycle it is
// high (including combinationally in the detect cycle); FLUSH_ID is a one-cycle
// bubble request into ID/EX in RESOLVE; PC_LD and FLUSH_IF are a one-cycle
// pulse pair in REDIRECT. No other handshaking exists: the pipeline must obey
// these levels in the cycle they are presented.
module branch_control_unit
    import branch_control_unit_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int FLAG_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ID_VALID,
    input  logic [3:0]        ID_BRANCH_TYPE,
    input  logic [ADDR_W-1:0] ID_BR_ADDR,
    input  logic              EX_FLAG_WR,
    input  logic              INT_FLUSH,
    input  logic              C_FLAG,
    input  logic              Z_FLAG,
    input  logic              BRANCH_TAKEN,
    output logic [3:0]        CALC_TYPE,
    output logic              CALC_C,
    output logic              CALC_Z,
    output logic              STALL,
    output logic              FLUSH_ID,
    output logic              FLUSH_IF,
    output logic              PC_LD,
    output logic [ADDR_W-1:0] PC_ADDR,
    output logic [CNT_W-1:0]  BR_COUNT,
    output logic [CNT_W-1:0]  TAKEN_COUNT,
    output logic [1:0]        dbg_state
);

    // The wait counter holds FLAG_LAT-1 down to 0.
    localparam int WCNT_W = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;

    bcu_state_t          state;
    bcu_state_t          next_state;
    logic [3:0]          lat_type;
    logic [ADDR_W-1:0]   lat_addr;
    logic [WCNT_W-1:0]   wait_cnt;

    logic                detect;
    logic                latch_en;
    logic                wait_load;
    logic                br_inc;
    logic                taken_inc;

    assign dbg_state = state;

    // Interrupt redirect and reset both pre-empt a new branch in ID.
    assign detect = ID_VALID && is_branch(ID_BRANCH_TYPE) && !INT_FLUSH && !RST;

    // Next-state and pipeline-control decode.
    always_comb begin
        next_state = state;
        latch_en   = 1'b0;
        wait_load  = 1'b0;
        br_inc     = 1'b0;
        taken_inc  = 1'b0;
        CALC_TYPE  = BR_NONE;
        CALC_C     = 1'b0;
        CALC_Z     = 1'b0;
        STALL      = 1'b0;
        FLUSH_ID   = 1'b0;
        FLUSH_IF   = 1'b0;
        PC_LD      = 1'b0;
        PC_ADDR    = '0;

        case (state)
            ST_IDLE: begin
                if (detect) begin
                    STALL    = 1'b1;
                    latch_en = 1'b1;
                    if (EX_FLAG_WR) begin
                        next_state = ST_WAIT;
                        wait_load  = 1'b1;
                    end else begin
                        next_state = ST_RESOLVE;
                    end
                end
            end
            ST_WAIT: begin
                // EX carries a bubble while we stall, so further flag writes are ignored.
                STALL = 1'b1;
                if (wait_cnt == '0) begin
                    next_state = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                STALL     = 1'b1;
                FLUSH_ID  = 1'b1;
                CALC_TYPE = lat_type;
                CALC_C    = C_FLAG;
                CALC_Z    = Z_FLAG;
                br_inc    = !INT_FLUSH;
                taken_inc = !INT_FLUSH && BRANCH_TAKEN;
                next_state = BRANCH_TAKEN ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                PC_LD      = 1'b1;
                PC_ADDR    = lat_addr;
                FLUSH_IF   = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (INT_FLUSH) begin
            next_state = ST_IDLE;
        end
    end

    // State register, branch latches and flag-latency wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            lat_type <= BR_NONE;
            lat_addr <= '0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (INT_FLUSH) begin
                lat_type <= BR_NONE;
                lat_addr <= '0;
                wait_cnt <= '0;
            end else begin
                if (latch_en) begin
                    lat_type <= ID_BRANCH_TYPE;
                    lat_addr <= ID_BR_ADDR;
                end
                if (wait_load) begin
                    wait_cnt <= WCNT_W'(FLAG_LAT - 1);
                end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                    wait_cnt <= wait_cnt - WCNT_W'(1);
                end
            end
        end
    end

    branch_stat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (br_inc),
        .count (BR_COUNT)
    );

    branch_stat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (taken_inc),
        .count (TAKEN_COUNT)
    );

endmodule

// File: tb/tb_branch_control_unit.sv
// Bench for branch_control_unit: randomized and directed branches, a
// transaction-level model of expected resolve/redirect events, and a monitor
// that matches every FLUSH_ID / PC_LD the DUT shows against the queue.
module tb_branch_control_unit;
    import branch_control_unit_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int FLAG_LAT = 2;

    localparam int M_NORMAL     = 0;
    localparam int M_INT_WAIT   = 1;
    localparam int M_INT_DETECT = 2;
    localparam int M_INT_RES    = 3;
    localparam int M_RST_RES    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              RST = 1'b1;
    logic              ID_VALID = 1'b0;
    logic [3:0]        ID_BRANCH_TYPE = 4'd0;
    logic [ADDR_W-1:0] ID_BR_ADDR = '0;
    logic              EX_FLAG_WR = 1'b0;
    logic              INT_FLUSH = 1'b0;
    logic              C_FLAG = 1'b0;
    logic              Z_FLAG = 1'b0;

    logic              BRANCH_TAKEN, CALC_C, CALC_Z, STALL, FLUSH_ID, FLUSH_IF, PC_LD;
    logic [3:0]        CALC_TYPE;
    logic [ADDR_W-1:0] PC_ADDR;
    logic [15:0]       BR_COUNT, TAKEN_COUNT;
    logic [1:0]        dbg_state;

    logic              s_taken, s_calc_c, s_calc_z, s_stall, s_flush_id, s_flush_if, s_pc_ld;
    logic [3:0]        s_calc_type;
    logic [ADDR_W-1:0] s_pc_addr;
    logic [3:0]        s_br_count, s_taken_count;
    logic [1:0]        s_dbg_state;

    // Behaviour of the external branch calculator.
    function automatic logic calc(input logic [3:0] t, input logic c, input logic z);
        case (t)
            4'd1:    return 1'b1;
            4'd2:    return z;
            4'd3:    return !z;
            4'd4:    return c;
            4'd5:    return !c;
            default: return 1'b0;
        endcase
    endfunction

    assign BRANCH_TAKEN = calc(CALC_TYPE, CALC_C, CALC_Z);
    assign s_taken      = calc(s_calc_type, s_calc_c, s_calc_z);

    branch_control_unit #(.ADDR_W(ADDR_W), .FLAG_LAT(FLAG_LAT), .CNT_W(16)) dut (
        .CLK(clk), .RST(RST), .ID_VALID(ID_VALID), .ID_BRANCH_TYPE(ID_BRANCH_TYPE),
        .ID_BR_ADDR(ID_BR_ADDR), .EX_FLAG_WR(EX_FLAG_WR), .INT_FLUSH(INT_FLUSH),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .BRANCH_TAKEN(BRANCH_TAKEN),
        .CALC_TYPE(CALC_TYPE), .CALC_C(CALC_C), .CALC_Z(CALC_Z), .STALL(STALL),
        .FLUSH_ID(FLUSH_ID), .FLUSH_IF(FLUSH_IF), .PC_LD(PC_LD), .PC_ADDR(PC_ADDR),
        .BR_COUNT(BR_COUNT), .TAKEN_COUNT(TAKEN_COUNT), .dbg_state(dbg_state)
    );

    // Narrow-counter build used for the saturation check; same stimulus.
    branch_control_unit #(.ADDR_W(ADDR_W), .FLAG_LAT(FLAG_LAT), .CNT_W(4)) dut_sat (
        .CLK(clk), .RST(RST), .ID_VALID(ID_VALID), .ID_BRANCH_TYPE(ID_BRANCH_TYPE),
        .ID_BR_ADDR(ID_BR_ADDR), .EX_FLAG_WR(EX_FLAG_WR), .INT_FLUSH(INT_FLUSH),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .BRANCH_TAKEN(s_taken),
        .CALC_TYPE(s_calc_type), .CALC_C(s_calc_c), .CALC_Z(s_calc_z), .STALL(s_stall),
        .FLUSH_ID(s_flush_id), .FLUSH_IF(s_flush_if), .PC_LD(s_pc_ld), .PC_ADDR(s_pc_addr),
        .BR_COUNT(s_br_count), .TAKEN_COUNT(s_taken_count), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int              cyc;
        bit              redirect;
        logic [3:0]      typ;
        logic            c;
        logic            z;
        logic [ADDR_W-1:0] addr;
        int              br;
        int              tk;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  br_cnt = 0;
    int  tk_cnt = 0;
    bit  mon_en = 1'b0;

    function automatic int sat(input int n, input int w);
        int m;
        m = (1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every resolve or redirect the DUT presents must match the queue head.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            if (FLUSH_ID || PC_LD) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, FLUSH_ID, PC_LD}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("br_count", {16'd0, BR_COUNT}, sat(e.br, 16));
                    check("taken_count", {16'd0, TAKEN_COUNT}, sat(e.tk, 16));
                    check("br_count4", {28'd0, s_br_count}, sat(e.br, 4));
                    check("taken_count4", {28'd0, s_taken_count}, sat(e.tk, 4));
                    if (e.redirect) begin
                        check("redirect_ctl", {28'd0, PC_LD, FLUSH_IF, FLUSH_ID, STALL}, 32'hC);
                        check("pc_addr", {22'd0, PC_ADDR}, {22'd0, e.addr});
                    end else begin
                        check("resolve_ctl", {28'd0, PC_LD, FLUSH_IF, FLUSH_ID, STALL}, 32'h3);
                        check("calc_inputs", {26'd0, CALC_TYPE, CALC_C, CALC_Z},
                              {26'd0, e.typ, e.c, e.z});
                    end
                end
            end else begin
                check("quiet_outputs", {15'd0, CALC_TYPE, CALC_C, CALC_Z, FLUSH_IF, PC_ADDR}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input bit exp, input string nm);
        @(negedge clk);
        check(nm, {31'd0, STALL}, {31'd0, exp});
    endtask

    task automatic chk_all_zero(input string nm);
        @(negedge clk);
        check({nm, "_ctl"}, {26'd0, STALL, FLUSH_ID, FLUSH_IF, PC_LD, CALC_C, CALC_Z}, 32'd0);
        check({nm, "_type_addr"}, {18'd0, CALC_TYPE, PC_ADDR}, 32'd0);
        check({nm, "_counts"}, {BR_COUNT, TAKEN_COUNT}, 32'd0);
        check({nm, "_counts4"}, {24'd0, s_br_count, s_taken_count}, 32'd0);
        check({nm, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    task automatic no_branch(input logic valid, input logic [3:0] t);
        ID_VALID = valid;
        ID_BRANCH_TYPE = t;
        EX_FLAG_WR = 1'($urandom);
        chk_stall(1'b0, "stall_no_branch");
        tick();
        ID_VALID = 1'b0;
        EX_FLAG_WR = 1'b0;
    endtask

    // Present one branch in ID and predict its resolve/redirect events.
    task automatic issue(input logic [3:0] t, input logic [ADDR_W-1:0] a, input bit haz,
                         input bit c, input bit z, input int mode);
        ev_t e;
        bit  tk;
        int  t0;
        int  n;
        t0 = cyc;
        C_FLAG = c;
        Z_FLAG = z;
        ID_VALID = 1'b1;
        ID_BRANCH_TYPE = t;
        ID_BR_ADDR = a;
        EX_FLAG_WR = haz;
        if (mode == M_INT_DETECT) begin
            INT_FLUSH = 1'b1;
            chk_stall(1'b0, "stall_int_same_cycle");
            tick();
            ID_VALID = 1'b0;
            INT_FLUSH = 1'b0;
            EX_FLAG_WR = 1'b0;
            chk_stall(1'b0, "stall_after_int_detect");
            tick();
            return;
        end
        tk = calc(t, c, z);
        n = haz ? (1 + FLAG_LAT) : 1;
        if (mode != M_INT_WAIT) begin
            e.cyc = t0 + n; e.redirect = 1'b0; e.typ = t; e.c = c; e.z = z;
            e.addr = '0; e.br = br_cnt; e.tk = tk_cnt;
            exp_q.push_back(e);
        end
        if (mode == M_NORMAL) begin
            br_cnt++;
            if (tk) begin
                tk_cnt++;
                e.cyc = t0 + n + 1; e.redirect = 1'b1; e.addr = a;
                e.br = br_cnt; e.tk = tk_cnt;
                exp_q.push_back(e);
            end
        end
        chk_stall(1'b1, "stall_detect");
        tick();
        ID_VALID = 1'b0;
        for (int i = 1; i <= n; i++) begin
            EX_FLAG_WR = 1'($urandom);
            if (mode == M_INT_WAIT) INT_FLUSH = 1'b1;
            if (i == n && mode == M_INT_RES) INT_FLUSH = 1'b1;
            if (i == n && mode == M_RST_RES) RST = 1'b1;
            chk_stall(1'b1, "stall_hold");
            tick();
            if (mode == M_INT_WAIT) break;
        end
        EX_FLAG_WR = 1'b0;
        INT_FLUSH = 1'b0;
        if (mode == M_RST_RES) begin
            RST = 1'b0;
            br_cnt = 0;
            tk_cnt = 0;
            chk_all_zero("after_mid_reset");
            tick();
        end
        if (mode == M_INT_WAIT) begin
            chk_stall(1'b0, "stall_after_int_wait");
            tick();
        end
        if (mode == M_NORMAL && tk) begin
            // A branch sitting in ID during the redirect is being squashed.
            ID_VALID = 1'b1;
            ID_BRANCH_TYPE = 4'($urandom_range(1, 5));
            chk_stall(1'b0, "stall_redirect");
            tick();
            ID_VALID = 1'b0;
        end else begin
            chk_stall(1'b0, "stall_released");
            tick();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] t;
        int r;
        repeat (3) tick();
        RST = 1'b0;
        chk_all_zero("reset");
        tick();
        mon_en = 1'b1;

        issue(BR_BRN,  10'h155, 1'b0, 1'b0, 1'b0, M_NORMAL);
        issue(BR_BREQ, 10'h0A3, 1'b0, 1'b1, 1'b0, M_NORMAL);
        issue(BR_BRCS, 10'h2F0, 1'b1, 1'b1, 1'b0, M_NORMAL);
        issue(BR_BRCS, 10'h111, 1'b1, 1'b1, 1'b0, M_INT_WAIT);
        issue(BR_BRN,  10'h222, 1'b0, 1'b0, 1'b0, M_INT_DETECT);
        issue(BR_BRN,  10'h333, 1'b0, 1'b0, 1'b0, M_INT_RES);
        no_branch(1'b1, BR_NONE);
        no_branch(1'b0, BR_BRN);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                t = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15))
                                                : 4'($urandom_range(1, 5));
                issue(t, ADDR_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), M_NORMAL);
            end else if (r == 8) begin
                no_branch(1'b1, BR_NONE);
            end else begin
                no_branch(1'b0, 4'($urandom_range(1, 5)));
            end
        end

        issue(BR_BRN, 10'h0F0, 1'b0, 1'b0, 1'b0, M_RST_RES);

        for (int k = 0; k < 20; k++) begin
            issue(BR_BRN, ADDR_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), M_NORMAL);
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_br_count", {16'd0, BR_COUNT}, sat(br_cnt, 16));
        check("final_taken_count", {16'd0, TAKEN_COUNT}, sat(tk_cnt, 16));
        check("sat_br_count4", {28'd0, s_br_count}, 32'd15);
        check("sat_taken_count4", {28'd0, s_taken_count}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
